// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/host memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_HOST = 1'b1
    } gnt_e;

    localparam int RD_LAT_MAX = 4;
    localparam int LAT_CW     = $clog2(RD_LAT_MAX);
    localparam int STARVE_CW  = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/ack bus for both requesters plus the RAM-side signals of the arbiter.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          i_cpu_req;
    logic          i_cpu_we;
    logic [AW-1:0] i_cpu_addr;
    logic [DW-1:0] i_cpu_wdata;
    logic          o_cpu_ack;
    logic [DW-1:0] o_cpu_rdata;
    logic          o_cpu_stall;

    logic          i_host_req;
    logic          i_host_we;
    logic [AW-1:0] i_host_addr;
    logic [DW-1:0] i_host_wdata;
    logic          o_host_ack;
    logic [DW-1:0] o_host_rdata;

    logic          o_mem_en;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_din;
    logic [DW-1:0] i_mem_dout;

    logic          o_busy;

    modport slave (
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        input  i_host_req, i_host_we, i_host_addr, i_host_wdata,
        input  i_mem_dout,
        output o_cpu_ack, o_cpu_rdata, o_cpu_stall,
        output o_host_ack, o_host_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_din,
        output o_busy
    );

    modport master (
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        output i_host_req, i_host_we, i_host_addr, i_host_wdata,
        output i_mem_dout,
        input  o_cpu_ack, o_cpu_rdata, o_cpu_stall,
        input  o_host_ack, o_host_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_din,
        input  o_busy
    );
endinterface

// File: rtl/mem_arb_select.sv
// Fixed CPU priority with a saturating host starvation counter that forces a host win.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_cpu_req,
    input  logic i_host_req,
    input  logic i_arb,
    input  gnt_e i_gnt,
    output gnt_e o_winner
);

    localparam logic [STARVE_CW-1:0] MAX_CNT = STARVE_CW'(HOST_MAX_WAIT);

    logic [STARVE_CW-1:0] cnt_q, cnt_d;

    always_comb begin
        o_winner = GNT_CPU;
        if (i_host_req && (!i_cpu_req || cnt_q == MAX_CNT)) begin
            o_winner = GNT_HOST;
        end
    end

    // While busy, the host only counts as waiting if it is not the current owner.
    always_comb begin
        cnt_d = cnt_q;
        if (i_arb) begin
            if (!i_host_req || o_winner == GNT_HOST) begin
                cnt_d = '0;
            end else if (cnt_q != MAX_CNT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (i_host_req && i_gnt != GNT_HOST && cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the CPU and the host loader port.
// state | meaning: IDLE arbitrate | ISSUE mem_en pulse | WAIT read latency | ACK ack pulse
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW            = 8,
    parameter int DW            = 16,
    parameter int RD_LAT        = 1,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    mem_arbiter_if.slave bus
);

    localparam logic [LAT_CW-1:0] LAT_LOAD = LAT_CW'(RD_LAT - 1);

    arb_state_e        state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    gnt_e              winner;
    logic [LAT_CW-1:0] lat_q, lat_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_din_q, mem_din_d;
    logic [DW-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]     host_rdata_q, host_rdata_d;
    logic              cpu_ack, host_ack;

    mem_arb_select #(
        .HOST_MAX_WAIT(HOST_MAX_WAIT)
    ) u_select (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_cpu_req (bus.i_cpu_req),
        .i_host_req(bus.i_host_req),
        .i_arb     (state_q == IDLE),
        .i_gnt     (gnt_q),
        .o_winner  (winner)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        lat_d        = lat_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.i_cpu_req || bus.i_host_req) begin
                    gnt_d    = winner;
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    if (winner == GNT_HOST) begin
                        mem_we_d   = bus.i_host_we;
                        mem_addr_d = bus.i_host_addr;
                        mem_din_d  = bus.i_host_wdata;
                    end else begin
                        mem_we_d   = bus.i_cpu_we;
                        mem_addr_d = bus.i_cpu_addr;
                        mem_din_d  = bus.i_cpu_wdata;
                    end
                end
            end
            ISSUE: begin
                // mem_we_q doubles as the latched direction for this access.
                if (mem_we_q) begin
                    state_d = ACK;
                end else begin
                    state_d = WAIT;
                    lat_d   = LAT_LOAD;
                end
            end
            WAIT: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else begin
                    state_d = ACK;
                    if (gnt_q == GNT_HOST) begin
                        host_rdata_d = bus.i_mem_dout;
                    end else begin
                        cpu_rdata_d = bus.i_mem_dout;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_CPU;
            lat_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            lat_q        <= lat_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign cpu_ack  = (state_q == ACK) && (gnt_q == GNT_CPU);
    assign host_ack = (state_q == ACK) && (gnt_q == GNT_HOST);

    assign bus.o_cpu_ack    = cpu_ack;
    assign bus.o_cpu_rdata  = cpu_rdata_q;
    assign bus.o_cpu_stall  = bus.i_cpu_req & ~cpu_ack;
    assign bus.o_host_ack   = host_ack;
    assign bus.o_host_rdata = host_rdata_q;
    assign bus.o_mem_en     = mem_en_q;
    assign bus.o_mem_we     = mem_we_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_din    = mem_din_q;
    assign bus.o_busy       = (state_q != IDLE);

endmodule
